fmul_post: RTL and testbench

- Registered post-processing stage directly downstream of the combinational `fmul` datapath.
- Takes the original operands and fmul's raw product, then fixes what fmul does not handle:
  - corrects the exponent;
  - zero, underflow, overflow, Inf and NaN cases.
- Buffers results in a 2-entry FIFO with valid/ready handshakes toward FPU writeback, and keeps a sticky overflow status bit.

---
 rtl/fmul_post.sv | 168 ++++++++++++++++
 tb/tb_fmul_post.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_post.sv
// rtl/fmul_post.sv - exponent/special-case correction stage behind fmul with a 2-entry result FIFO
//
// Purpose:
//    Takes the operands and the raw product of the combinational fmul datapath,
//    repairs the exponent and resolves zero/underflow/overflow/Inf/NaN, then
//    buffers the corrected result in a 2-entry FIFO toward FPU writeback.
//
// Ports:
//    clk         clock
//    rstn        asynchronous active-low reset
//    in_valid    x1/x2/y_raw valid this cycle
//    in_ready    stage can accept (count < DEPTH)
//    x1, x2      operands, same values fed to fmul
//    y_raw       fmul product for x1, x2
//    out_valid   head result valid
//    out_ready   consumer accepts the head
//    y           corrected product at the FIFO head
//    ovf         head result overflowed to Inf
//    ovf_sticky  OR of all accepted ovf bits since the last clear
//    clr_sticky  clears ovf_sticky (a simultaneous overflow push wins)

module fmul_post #(
   parameter logic [31:0] NAN_VAL = 32'h7FC00000,
   parameter int          DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic [31:0] y_raw,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf,
   output logic        ovf_sticky,
   input  logic        clr_sticky
);

   // ------------------------------------------------------------------
   // Field split
   // ------------------------------------------------------------------
   logic        s;
   logic [7:0]  e1, e2, ey;
   logic [22:0] m1, m2;
   logic        nan1, nan2, inf1, inf2, zer1, zer2;
   logic        unused_raw_sign;

   assign s  = x1[31] ^ x2[31];
   assign e1 = x1[30:23];
   assign e2 = x2[30:23];
   assign ey = y_raw[30:23];
   assign m1 = x1[22:0];
   assign m2 = x2[22:0];

   // The sign of the raw product is recomputed from the operands.
   assign unused_raw_sign = y_raw[31];

   assign nan1 = (e1 == 8'hFF) && (m1 != 23'd0);
   assign nan2 = (e2 == 8'hFF) && (m2 != 23'd0);
   assign inf1 = (e1 == 8'hFF) && (m1 == 23'd0);
   assign inf2 = (e2 == 8'hFF) && (m2 == 23'd0);
   // Denormals are flushed, so any zero exponent counts as zero.
   assign zer1 = (e1 == 8'd0);
   assign zer2 = (e2 == 8'd0);

   // ------------------------------------------------------------------
   // Exponent correction
   // ------------------------------------------------------------------
   // fmul leaves a fixed offset in its exponent; the residue mod 4 of
   // (ey - e1 - e2 - 129) tells whether the significand product landed in
   // [1,2) (k=1) or [2,4) (k=2). Only the low two bits matter for a mod-4
   // result under 8-bit wrap, and 129 mod 4 is 1.
   logic [1:0]         k;
   logic               k_is_2;
   logic signed [10:0] exp_c;

   assign k      = ey[1:0] - e1[1:0] - e2[1:0] - 2'd1;
   assign k_is_2 = (k == 2'd2);

   // Any k other than 2 behaves like 1, so the (k - 1) term is 0 or 1.
   assign exp_c = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127
                + (k_is_2 ? 11'sd1 : 11'sd0);

   // ------------------------------------------------------------------
   // Result selection, highest priority first
   // ------------------------------------------------------------------
   logic [31:0] res_y;
   logic        res_ovf;

   always_comb begin
      res_y   = {s, exp_c[7:0], y_raw[22:0]};
      res_ovf = 1'b0;
      if (nan1 || nan2) begin
         res_y = NAN_VAL;
      end else if ((inf1 && zer2) || (inf2 && zer1)) begin
         // Inf * 0 is invalid
         res_y = NAN_VAL;
      end else if (inf1 || inf2) begin
         res_y = {s, 8'hFF, 23'd0};
      end else if (zer1 || zer2) begin
         res_y = {s, 31'd0};
      end else if (exp_c <= 11'sd0) begin
         // Underflow is flushed to signed zero without a flag.
         res_y = {s, 31'd0};
      end else if (exp_c >= 11'sd255) begin
         res_y   = {s, 8'hFF, 23'd0};
         res_ovf = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------
   logic [31:0] mem_y   [2];
   logic        mem_ovf [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   // in_ready looks only at the occupancy, never at out_ready, so a full
   // FIFO cannot push and pop in the same cycle.
   assign in_ready  = (count < 2'(DEPTH));
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign y   = mem_y[rd_ptr];
   assign ovf = mem_ovf[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // Storage is cleared too so y/ovf read zero while empty after reset.
         for (int i = 0; i < 2; i++) begin
            mem_y[i]   <= 32'd0;
            mem_ovf[i] <= 1'b0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         ovf_sticky <= 1'b0;
      end else begin
         if (push) begin
            mem_y[wr_ptr]   <= res_y;
            mem_ovf[wr_ptr] <= res_ovf;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         // An overflowing push in the same cycle as a clear keeps the flag set.
         if (push && res_ovf) begin
            ovf_sticky <= 1'b1;
         end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fmul_post.sv
// tb/tb_fmul_post.sv - self-checking bench for fmul_post with a queue-based reference model

module tb_fmul_post;

   localparam logic [31:0] NAN_Q = 32'h7FC00000;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x1;
   logic [31:0] x2;
   logic [31:0] y_raw;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf;
   logic        ovf_sticky;
   logic        clr_sticky;

   int n_chk  = 0;
   int n_fail = 0;

   logic [32:0] q[$];
   logic        sticky_m;

   fmul_post dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x1         (x1),
      .x2         (x2),
      .y_raw      (y_raw),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y          (y),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky),
      .clr_sticky (clr_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: returns {ovf, y} from the rules on plain integers.
   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] r);
      int ea, eb, er, k, e;
      logic sg, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
      logic [7:0] e8;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      er = int'(r[30:23]);
      sg = a[31] ^ b[31];
      nan_a = (ea == 255) && (a[22:0] != 0);
      nan_b = (eb == 255) && (b[22:0] != 0);
      inf_a = (ea == 255) && (a[22:0] == 0);
      inf_b = (eb == 255) && (b[22:0] == 0);
      zer_a = (ea == 0);
      zer_b = (eb == 0);
      if (nan_a || nan_b) return {1'b0, NAN_Q};
      if ((inf_a && zer_b) || (inf_b && zer_a)) return {1'b0, NAN_Q};
      if (inf_a || inf_b) return {1'b0, sg, 8'hFF, 23'd0};
      if (zer_a || zer_b) return {1'b0, sg, 31'd0};
      k = (er - ea - eb - 129) % 4;
      if (k < 0) k += 4;
      if (k != 2) k = 1;
      e = ea + eb - 127 + (k - 1);
      if (e <= 0) return {1'b0, sg, 31'd0};
      if (e >= 255) return {1'b1, sg, 8'hFF, 23'd0};
      e8 = 8'(e);
      return {1'b0, sg, e8, r[22:0]};
   endfunction

   task automatic check_all();
      logic [32:0] h;
      chk("in_ready", in_ready, 32'(q.size() < 2));
      chk("out_valid", out_valid, 32'(q.size() > 0));
      if (q.size() > 0) begin
         h = q[0];
         chk("y", y, h[31:0]);
         chk("ovf", ovf, 32'(h[32]));
      end
      chk("ovf_sticky", ovf_sticky, 32'(sticky_m));
   endtask

   // Called just after a negedge: drive, model the clock edge, check at next negedge.
   task automatic tick(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic ordy, input logic clr);
      logic do_push, do_pop;
      logic [32:0] res;
      in_valid   = iv;
      x1         = a;
      x2         = b;
      y_raw      = r;
      out_ready  = ordy;
      clr_sticky = clr;
      do_push = iv && (q.size() < 2);
      do_pop  = ordy && (q.size() > 0);
      res = ref_mul(a, b, r);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(res);
      if (do_push && res[32]) sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int c;
      v = $urandom;
      c = $urandom_range(0, 11);
      case (c)
         0: v[30:23] = 8'd0;
         1: v[30:0] = {8'hFF, 23'd0};
         2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
         3, 4: v[30:23] = 8'($urandom_range(190, 254));
         5: v[30:23] = 8'($urandom_range(1, 64));
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rand_raw(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int s;
      r = $urandom;
      if ($urandom_range(0, 4) != 0) begin
         s = int'(a[30:23]) + int'(b[30:23]) - 126 + int'($urandom_range(0, 1));
         r[30:23] = 8'(s);
      end
      return r;
   endfunction

   initial begin
      logic [31:0] a, b;
      rstn = 1'b0;
      in_valid = 1'b0;
      x1 = 32'd0;
      x2 = 32'd0;
      y_raw = 32'd0;
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      sticky_m = 1'b0;

      #2;
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_y", y, 32'd0);
      chk("rst_ovf", ovf, 32'd0);
      chk("rst_sticky", ovf_sticky, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_all();

      // 1: 2.0 * 3.0
      tick(1'b1, 32'h40000000, 32'h40400000, 32'h41400000, 1'b1, 1'b0);
      chk("t1_y", y, 32'h40C00000);
      chk("t1_ovf", ovf, 32'd0);

      // 2: overflow then sticky clear
      tick(1'b1, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
      chk("t2_y", y, 32'h7F800000);
      chk("t2_ovf", ovf, 32'd1);
      chk("t2_sticky", ovf_sticky, 32'd1);
      tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      chk("t2_clr", ovf_sticky, 32'd0);

      // 3: zero and Inf*0
      tick(1'b1, 32'h00000000, 32'hC0000000, 32'h12345678, 1'b1, 1'b0);
      chk("t3_zero", y, 32'h80000000);
      tick(1'b1, 32'h7F800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
      chk("t3_nan", y, 32'h7FC00000);

      // 4: underflow
      tick(1'b1, 32'h1F000000, 32'h1F000000, 32'h00800000, 1'b1, 1'b0);
      chk("t4_y", y, 32'h00000000);
      chk("t4_ovf", ovf, 32'd0);
      tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 5: backpressure
      tick(1'b1, 32'h40000000, 32'h40400000, 32'h41400000, 1'b0, 1'b0);
      tick(1'b1, 32'h3F800000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
      chk("bp_full", in_ready, 32'd0);
      tick(1'b1, 32'h40400000, 32'h40400000, 32'h41900000, 1'b0, 1'b0);
      chk("bp_hold_y", y, 32'h40C00000);
      tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("bp_ready_back", in_ready, 32'd1);
      chk("bp_second", y, 32'h40000000);
      tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("bp_empty", out_valid, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         a = rand_op();
         b = rand_op();
         tick(1'($urandom_range(0, 3) != 0), a, b, rand_raw(a, b),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 6: reset with two buffered entries
      tick(1'b1, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0);
      tick(1'b1, 32'h40000000, 32'h40400000, 32'h41400000, 1'b0, 1'b0);
      chk("pre_rst_full", in_ready, 32'd0);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 32'd0);
      chk("mid_rst_sticky", ovf_sticky, 32'd0);
      q.delete();
      sticky_m = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("post_rst_ready", in_ready, 32'd1);
      tick(1'b1, 32'h40000000, 32'h40400000, 32'h41400000, 1'b1, 1'b0);
      chk("post_rst_y", y, 32'h40C00000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
